// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - command, operand and HI/LO result bundle of the multiply/divide sequencer
interface muldiv_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] Read_data_1;
  logic [31:0] Read_data_2;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] Write_data;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] HI;
  logic [31:0] LO;

  // Core side: issues operations and mthi/mtlo writes, observes results
  modport master (
    output start, op, Read_data_1, Read_data_2, hi_we, lo_we, Write_data,
    input  busy, done, div_zero, HI, LO
  );

  // Sequencer side
  modport slave (
    input  start, op, Read_data_1, Read_data_2, hi_we, lo_we, Write_data,
    output busy, done, div_zero, HI, LO
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - 33-cycle shift-add / restoring-divide sequencer owning HI/LO
module muldiv_unit (
  input logic          clock,
  input logic          reset,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q;
  logic [31:0] mcand_q;   // multiplicand magnitude, or divisor magnitude for div/divu
  logic [31:0] mplr_q;    // multiplier magnitude (multiply only)
  logic [63:0] acc_q;     // product accumulator, or {remainder, quotient} for divide
  logic [31:0] dividend_q;
  logic        sign_a_q, sign_b_q;
  logic [5:0]  cnt_q;
  logic        busy_q, done_q, div_zero_q;
  logic [31:0] hi_q, lo_q;

  logic        start_ok;
  logic        new_signed;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic        is_div, is_signed;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;

  assign start_ok   = (state_q == IDLE) && bus.start;
  assign new_signed = ~bus.op[0];
  assign abs_a      = (new_signed && bus.Read_data_1[31]) ? -bus.Read_data_1 : bus.Read_data_1;
  assign abs_b      = (new_signed && bus.Read_data_2[31]) ? -bus.Read_data_2 : bus.Read_data_2;

  // One shift-add step: add into the upper half with the carry kept, then shift right
  assign mul_sum   = {1'b0, acc_q[63:32]} + (mplr_q[0] ? {1'b0, mcand_q} : 33'd0);
  // One restoring step: shift {rem, quot} left and trial-subtract the divisor
  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, mcand_q};

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign prod_fix  = (is_signed && (sign_a_q ^ sign_b_q)) ? -acc_q : acc_q;
  assign quot_fix  = (is_signed && (sign_a_q ^ sign_b_q)) ? -acc_q[31:0] : acc_q[31:0];
  assign rem_fix   = (is_signed && sign_a_q) ? -acc_q[63:32] : acc_q[63:32];

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: 32 CALC iterations then a single sign-fix/writeback cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CALC;
      CALC:    if (cnt_q == 6'd31) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch and iterative datapath
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q       <= 2'b00;
      mcand_q    <= 32'd0;
      mplr_q     <= 32'd0;
      acc_q      <= 64'd0;
      dividend_q <= 32'd0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      cnt_q      <= 6'd0;
    end else if (start_ok) begin
      op_q       <= bus.op;
      dividend_q <= bus.Read_data_1;
      sign_a_q   <= new_signed & bus.Read_data_1[31];
      sign_b_q   <= new_signed & bus.Read_data_2[31];
      cnt_q      <= 6'd0;
      if (bus.op[1]) begin
        mcand_q <= abs_b;
        mplr_q  <= 32'd0;
        acc_q   <= {32'd0, abs_a};
      end else begin
        mcand_q <= abs_a;
        mplr_q  <= abs_b;
        acc_q   <= 64'd0;
      end
    end else if (state_q == CALC) begin
      cnt_q <= cnt_q + 6'd1;
      if (is_div) begin
        if (!div_diff[33]) acc_q <= {div_diff[31:0], acc_q[30:0], 1'b1};
        else               acc_q <= {div_shift[31:0], acc_q[30:0], 1'b0};
      end else begin
        acc_q  <= {mul_sum, acc_q[31:1]};
        mplr_q <= {1'b0, mplr_q[31:1]};
      end
    end
  end

  // HI/LO writeback, mthi/mtlo, and the registered status outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      busy_q     <= (state_d != IDLE);
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      if (state_q == FIX) begin
        done_q <= 1'b1;
        if (!is_div) begin
          hi_q <= prod_fix[63:32];
          lo_q <= prod_fix[31:0];
        end else if (mcand_q == 32'd0) begin
          hi_q       <= dividend_q;
          lo_q       <= 32'hFFFF_FFFF;
          div_zero_q <= 1'b1;
        end else begin
          hi_q <= rem_fix;
          lo_q <= quot_fix;
        end
      end else if (state_q == IDLE && !bus.start) begin
        if (bus.hi_we) hi_q <= bus.Write_data;
        if (bus.lo_we) lo_q <= bus.Write_data;
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clock = ~clock;

  muldiv_unit_if bus();
  muldiv_unit dut (.clock(clock), .reset(reset), .bus(bus));

  // Present an operation for one sampling edge, then scramble the operands
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.op = op; bus.Read_data_1 = a; bus.Read_data_2 = b; bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0; bus.Read_data_1 = ~a; bus.Read_data_2 = ~b;
  endtask

  // Count busy cycles until done, bounded to 40 cycles
  task automatic wait_done(output int cycles, output logic seen);
    seen = 1'b0; cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.done) begin seen = 1'b1; break; end
      if (bus.busy) cycles++;
    end
  endtask

  task automatic test_reset();
    #2;
    total++; if ({bus.busy, bus.done, bus.div_zero} !== 3'b000) $display("FAIL reset_flags got %b want 000", {bus.busy, bus.done, bus.div_zero}); else passed++;
    total++; if ({bus.HI, bus.LO} !== 64'd0) $display("FAIL reset_hilo got %h want 0", {bus.HI, bus.LO}); else passed++;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_multu_max();
    int c; logic s;
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(c, s);
    total++; if (s !== 1'b1) $display("FAIL multu_max_done got %b want 1", s); else passed++;
    total++; if (c != 33) $display("FAIL multu_max_busy_cycles got %0d want 33", c); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL multu_max_busy_at_done got %b want 0", bus.busy); else passed++;
    total++; if (bus.HI !== 32'hFFFF_FFFE) $display("FAIL multu_max_hi got %h want fffffffe", bus.HI); else passed++;
    total++; if (bus.LO !== 32'h0000_0001) $display("FAIL multu_max_lo got %h want 00000001", bus.LO); else passed++;
    total++; if (bus.div_zero !== 1'b0) $display("FAIL multu_max_dz got %b want 0", bus.div_zero); else passed++;
    @(negedge clock);
    total++; if (bus.done !== 1'b0) $display("FAIL multu_max_done_pulse got %b want 0", bus.done); else passed++;
  endtask

  task automatic test_mult_signed();
    int c; logic s;
    launch(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done(c, s);
    total++; if ({s, bus.HI, bus.LO} !== {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB}) $display("FAIL mult_neg got %b %h %h want 1 ffffffff ffffffeb", s, bus.HI, bus.LO); else passed++;
    launch(2'b01, 32'hFFFF_FFFD, 32'd7);
    wait_done(c, s);
    total++; if ({s, bus.HI, bus.LO} !== {1'b1, 32'h0000_0006, 32'hFFFF_FFEB}) $display("FAIL multu_big got %b %h %h want 1 00000006 ffffffeb", s, bus.HI, bus.LO); else passed++;
  endtask

  task automatic test_div();
    int c; logic s;
    launch(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(c, s);
    total++; if ({s, bus.HI, bus.LO} !== {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD}) $display("FAIL div_neg got %b %h %h want 1 ffffffff fffffffd", s, bus.HI, bus.LO); else passed++;
    total++; if (c != 33) $display("FAIL div_busy_cycles got %0d want 33", c); else passed++;
    launch(2'b11, 32'd100, 32'd7);
    wait_done(c, s);
    total++; if ({s, bus.HI, bus.LO} !== {1'b1, 32'd2, 32'd14}) $display("FAIL divu_100_7 got %b %h %h want 1 00000002 0000000e", s, bus.HI, bus.LO); else passed++;
  endtask

  task automatic test_div_zero();
    int c; logic s;
    launch(2'b11, 32'h64, 32'd0);
    wait_done(c, s);
    total++; if ({s, bus.div_zero} !== 2'b11) $display("FAIL divu_zero_flags got %b want 11", {s, bus.div_zero}); else passed++;
    total++; if ({bus.HI, bus.LO} !== {32'h64, 32'hFFFF_FFFF}) $display("FAIL divu_zero_hilo got %h %h want 00000064 ffffffff", bus.HI, bus.LO); else passed++;
    total++; if (c != 33) $display("FAIL divu_zero_cycles got %0d want 33", c); else passed++;
    @(negedge clock);
    total++; if (bus.div_zero !== 1'b0) $display("FAIL divu_zero_pulse got %b want 0", bus.div_zero); else passed++;
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(c, s);
    total++; if ({s, bus.div_zero, bus.HI, bus.LO} !== {2'b10, 32'd0, 32'h8000_0000}) $display("FAIL div_ovf got %b %b %h %h want 1 0 00000000 80000000", s, bus.div_zero, bus.HI, bus.LO); else passed++;
  endtask

  task automatic test_mthi_mtlo();
    int c; logic s;
    @(negedge clock);
    bus.hi_we = 1'b1; bus.Write_data = 32'h1234;
    @(negedge clock);
    bus.hi_we = 1'b0;
    total++; if (bus.HI !== 32'h1234) $display("FAIL mthi got %h want 00001234", bus.HI); else passed++;
    bus.lo_we = 1'b1; bus.Write_data = 32'h5678;
    @(negedge clock);
    bus.lo_we = 1'b0;
    total++; if (bus.LO !== 32'h5678) $display("FAIL mtlo got %h want 00005678", bus.LO); else passed++;
    launch(2'b01, 32'd2, 32'd3);
    @(negedge clock);
    bus.hi_we = 1'b1; bus.Write_data = 32'hDEAD;
    repeat (3) @(negedge clock);
    total++; if (bus.HI !== 32'h1234) $display("FAIL mthi_busy got %h want 00001234", bus.HI); else passed++;
    bus.hi_we = 1'b0;
    wait_done(c, s);
    total++; if ({s, bus.HI, bus.LO} !== {1'b1, 32'd0, 32'd6}) $display("FAIL mthi_busy_result got %b %h %h want 1 00000000 00000006", s, bus.HI, bus.LO); else passed++;
    @(negedge clock);
    bus.start = 1'b1; bus.op = 2'b01; bus.Read_data_1 = 32'd4; bus.Read_data_2 = 32'd5;
    bus.lo_we = 1'b1; bus.Write_data = 32'hAAAA;
    @(posedge clock);
    #1;
    bus.start = 1'b0; bus.lo_we = 1'b0;
    total++; if ({bus.busy, bus.LO} !== {1'b1, 32'd6}) $display("FAIL start_lo_we got %b %h want 1 00000006", bus.busy, bus.LO); else passed++;
    wait_done(c, s);
    total++; if ({s, bus.LO} !== {1'b1, 32'd20}) $display("FAIL start_lo_we_result got %b %h want 1 00000014", s, bus.LO); else passed++;
  endtask

  task automatic test_back_to_back();
    int c; logic s;
    launch(2'b11, 32'd100, 32'd7);
    wait_done(c, s);
    bus.start = 1'b1; bus.op = 2'b01; bus.Read_data_1 = 32'd6; bus.Read_data_2 = 32'd7;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    total++; if ({s, bus.busy, bus.HI, bus.LO} !== {2'b11, 32'd2, 32'd14}) $display("FAIL b2b_accept got %b %b %h %h want 1 1 00000002 0000000e", s, bus.busy, bus.HI, bus.LO); else passed++;
    wait_done(c, s);
    total++; if ({s, bus.LO} !== {1'b1, 32'd42}) $display("FAIL b2b_result got %b %h want 1 0000002a", s, bus.LO); else passed++;
    total++; if (c != 33) $display("FAIL b2b_cycles got %0d want 33", c); else passed++;
  endtask

  task automatic test_reset_mid();
    int c; logic s; logic any_done;
    launch(2'b00, 32'd9, 32'd9);
    repeat (9) @(negedge clock);
    bus.start = 1'b1; bus.op = 2'b11;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (5) @(negedge clock);
    total++; if (bus.busy !== 1'b1) $display("FAIL mid_busy_before_reset got %b want 1", bus.busy); else passed++;
    reset = 1'b1;
    #1;
    total++; if ({bus.busy, bus.done, bus.HI, bus.LO} !== {2'b00, 64'd0}) $display("FAIL mid_reset_state got %b %b %h %h want 0 0 0 0", bus.busy, bus.done, bus.HI, bus.LO); else passed++;
    @(negedge clock);
    reset = 1'b0;
    any_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.done || bus.busy) any_done = 1'b1;
    end
    total++; if (any_done !== 1'b0) $display("FAIL mid_reset_no_done got %b want 0", any_done); else passed++;
    launch(2'b01, 32'd3, 32'd5);
    wait_done(c, s);
    total++; if ({s, bus.HI, bus.LO} !== {1'b1, 32'd0, 32'd15}) $display("FAIL post_reset_multu got %b %h %h want 1 00000000 0000000f", s, bus.HI, bus.LO); else passed++;
    total++; if (c != 33) $display("FAIL post_reset_cycles got %0d want 33", c); else passed++;
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.Read_data_1 = 32'd0; bus.Read_data_2 = 32'd0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.Write_data = 32'd0;
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_div();
    test_div_zero();
    test_mthi_mtlo();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
